// File: rtl/y86_pkg.sv
// Shared Y86-64 SEQ definitions: status codes, instruction codes,
// sequencer state encoding and the stage-enable bundle.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'd8;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd1;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_PAUSE,
        ST_STOPPED
    } seq_state_e;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic memory;
        logic writeback;
        logic pc;
    } stage_en_t;

    // Only the six active stages strobe; IDLE, PAUSE and STOPPED are quiet.
    function automatic stage_en_t stage_en(seq_state_e s);
        stage_en_t e;
        e = '0;
        unique case (s)
            ST_FETCH:     e.fetch     = 1'b1;
            ST_DECODE:    e.decode    = 1'b1;
            ST_EXECUTE:   e.execute   = 1'b1;
            ST_MEMORY:    e.memory    = 1'b1;
            ST_WRITEBACK: e.writeback = 1'b1;
            ST_PCUPD:     e.pc        = 1'b1;
            default:      e           = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Host/stage side bundle of the SEQ sequencer: fault inputs, next PC,
// and the strobes, PC, status and counters it drives back.
interface y86_seq_ctrl_if #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
);
    logic             start;
    logic             in_error;
    logic             flag_halt;
    logic             bad_mem;
    logic             bad_mem2;
    logic [PC_W-1:0]  p_ctr_final;
    logic             step;

    logic [PC_W-1:0]  p_ctr;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pc_en;
    logic [3:0]       stat;
    logic [CNT_W-1:0] retired;
    logic             done;
    logic             budget_hit;

    modport master (
        output start, in_error, flag_halt, bad_mem, bad_mem2,
        output p_ctr_final, step,
        input  p_ctr, fetch_en, decode_en, execute_en,
        input  memory_en, writeback_en, pc_en,
        input  stat, retired, done, budget_hit
    );

    modport slave (
        input  start, in_error, flag_halt, bad_mem, bad_mem2,
        input  p_ctr_final, step,
        output p_ctr, fetch_en, decode_en, execute_en,
        output memory_en, writeback_en, pc_en,
        output stat, retired, done, budget_hit
    );

endinterface

// File: rtl/y86_stat_prio.sv
// Fetch-stage fault priority: invalid instruction beats bad
// instruction address, which beats halt.
module y86_stat_prio
    import y86_pkg::*;
(
    input  logic       in_error_i,
    input  logic       bad_mem_i,
    input  logic       flag_halt_i,
    output logic       fault_o,
    output logic [3:0] code_o
);

    always_comb begin
        fault_o = in_error_i | bad_mem_i | flag_halt_i;
        code_o  = STAT_AOK;
        if (in_error_i) begin
            code_o = STAT_INS;
        end else if (bad_mem_i) begin
            code_o = STAT_ADR;
        end else if (flag_halt_i) begin
            code_o = STAT_HLT;
        end
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle SEQ sequencer: stage strobes, PC, status, retire count.
// Define SEQ_STEP_EN to pause after every instruction until a step pulse.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int              PC_W      = 64,
    parameter int              CNT_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              MAX_INSNS = 0
) (
    input logic           clock,
    input logic           reset,
    y86_seq_ctrl_if.slave bus
);

    localparam bit               BUDGET_ON = (MAX_INSNS != 0);
    localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(MAX_INSNS);

`ifdef SEQ_STEP_EN
    localparam seq_state_e AFTER_PCUPD = ST_PAUSE;
`else
    localparam seq_state_e AFTER_PCUPD = ST_FETCH;
`endif

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  p_ctr_q, p_ctr_d;
    logic [3:0]       stat_q, stat_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             budget_q, budget_d;

    logic             fault;
    logic [3:0]       fault_code;
    logic [CNT_W-1:0] retired_inc;
    logic             budget_stop;
    stage_en_t        en;

    y86_stat_prio u_prio (
        .in_error_i  (bus.in_error),
        .bad_mem_i   (bus.bad_mem),
        .flag_halt_i (bus.flag_halt),
        .fault_o     (fault),
        .code_o      (fault_code)
    );

    assign retired_inc = (&retired_q) ? retired_q
                                      : retired_q + CNT_W'(1);
    assign budget_stop = BUDGET_ON && (retired_inc == BUDGET);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = fault ? ST_STOPPED : ST_DECODE;
            end
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEMORY;
            ST_MEMORY: begin
                state_d = bus.bad_mem2 ? ST_STOPPED : ST_WRITEBACK;
            end
            ST_WRITEBACK: state_d = ST_PCUPD;
            ST_PCUPD: begin
                state_d = budget_stop ? ST_STOPPED : AFTER_PCUPD;
            end
            ST_PAUSE: begin
`ifdef SEQ_STEP_EN
                if (bus.step) state_d = ST_FETCH;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_STOPPED:   state_d = ST_STOPPED;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        en = stage_en(state_q);
    end

    // Architectural state only changes in the state that owns each input.
    always_comb begin
        p_ctr_d   = p_ctr_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        budget_d  = budget_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) p_ctr_d = RESET_PC;
            end
            ST_FETCH: begin
                if (fault) stat_d = fault_code;
            end
            ST_MEMORY: begin
                if (bus.bad_mem2) stat_d = STAT_ADR;
            end
            ST_PCUPD: begin
                p_ctr_d   = bus.p_ctr_final;
                retired_d = retired_inc;
                budget_d  = budget_stop;
            end
            default: begin
                p_ctr_d = p_ctr_q;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_ctr_q   <= RESET_PC;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
            budget_q  <= 1'b0;
        end else begin
            p_ctr_q   <= p_ctr_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
            budget_q  <= budget_d;
        end
    end

`ifndef SEQ_STEP_EN
    logic step_unused;
    assign step_unused = bus.step;
`endif

    assign bus.p_ctr        = p_ctr_q;
    assign bus.stat         = stat_q;
    assign bus.retired      = retired_q;
    assign bus.budget_hit   = budget_q;
    assign bus.done         = (state_q == ST_STOPPED);
    assign bus.fetch_en     = en.fetch;
    assign bus.decode_en    = en.decode;
    assign bus.execute_en   = en.execute;
    assign bus.memory_en    = en.memory;
    assign bus.writeback_en = en.writeback;
    assign bus.pc_en        = en.pc;

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ datapath; replaces free-running combinational PC feedback and simulation-only stop logic.
- Drives one-hot stage enables (fetch, decode, execute, memory, writeback, pc_update), owns the PC register, and latches the architectural status code.
- Counts retired instructions and enforces an optional instruction budget; sits at the top level between the testbench/host and the six stage modules.

Parameters:
- PC_W, 64, width of p_ctr and p_ctr_final.
- CNT_W, 32, width of the retired-instruction counter.
- RESET_PC, 0, PC value loaded on reset and on start.
- MAX_INSNS, 0, instruction budget; 0 = unlimited.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; leaves IDLE.
- in_error  in  1  fetch: invalid instruction.
- flag_halt  in  1  fetch: halt decoded.
- bad_mem  in  1  fetch: bad instruction address.
- bad_mem2  in  1  memory: bad data address.
- p_ctr_final  in  PC_W  next PC from pc_update.
- step  in  1  single-step pulse (used only with SEQ_STEP_EN).
- p_ctr  out  PC_W  current PC to fetch.
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  one-hot stage strobes.
- stat  out  4  8=AOK, 2=HLT, 1=ADR, 4=INS.
- retired  out  CNT_W  instructions completed.
- done  out  1  high in STOPPED.
- budget_hit  out  1  stop caused by MAX_INSNS.

Behaviour:
- Reset (async, any state): state=IDLE, p_ctr=RESET_PC, stat=8, retired=0, done=0, budget_hit=0, all enables 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE, STOPPED.
- IDLE: start=1 -> FETCH; p_ctr reloaded with RESET_PC.
- Each state X in FETCH..PCUPD asserts exactly its own enable for that one cycle. Nominal instruction is 6 cycles.
- End of FETCH, priority in_error > bad_mem > flag_halt:
  - in_error -> stat=4.
  - bad_mem -> stat=1.
  - flag_halt -> stat=2.
  - Any of these -> STOPPED. DECODE..PCUPD are not entered, p_ctr is unchanged, and retired is not incremented. HLT therefore does not count as retired.
- End of MEMORY: bad_mem2 -> stat=1, STOPPED. WRITEBACK and PCUPD are suppressed.
- PCUPD:
  - p_ctr <= p_ctr_final; retired <= retired+1, saturating at all-ones.
  - If MAX_INSNS!=0 and the new retired==MAX_INSNS -> budget_hit=1, STOPPED, stat stays 8.
  - Otherwise -> FETCH, or PAUSE when stepping.
- Fault inputs are sampled only in their owning state and ignored elsewhere.
- STOPPED: done=1 and all enables 0. The state is sticky, start is ignored, and only reset exits.
- start during any non-IDLE state: ignored.
- Reset mid-instruction: the partial instruction is discarded; no enable is asserted in the cycle following reset deassertion.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined:
  - After PCUPD (when not stopping), the FSM enters PAUSE with all enables 0.
  - A step pulse moves PAUSE -> FETCH on the next edge.
  - step outside PAUSE is ignored.
- Undefined: PAUSE is unreachable, the step port exists but is ignored, and PCUPD -> FETCH directly.

Decomposition:
- Shared package y86_pkg holds:
  - stat constants STAT_AOK=4'd8, STAT_HLT=4'd2, STAT_ADR=4'd1, STAT_INS=4'd4.
  - The state enum.
  - Y86 icode constants (used by the stages).
- One natural sub-module, y86_stat_prio: combinational fetch-fault priority encoder (in_error, bad_mem, flag_halt -> fault, code).
- FSM, PC register and counter stay in the top of the block.

Test Plan:
- Reset then start; stages report no faults; p_ctr_final = p_ctr+10.
  -> Enables strobe in order F,D,E,M,W,P for one cycle each.
  -> After the first PCUPD: p_ctr=10, retired=1; after 3 instructions p_ctr=30, retired=3, stat=8.
- flag_halt=1 in FETCH of the 3rd instruction.
  -> stat=2, done=1, retired=2, p_ctr=20.
  -> No decode_en is ever seen for that instruction; a later start is ignored.
- in_error=1 and bad_mem=1 together in FETCH.
  -> stat=4; in_error wins the priority.
- bad_mem2=1 in MEMORY of the 1st instruction.
  -> stat=1, writeback_en and pc_en never assert, retired=0.
- MAX_INSNS=4, no faults.
  -> Stops after the 4th PCUPD with budget_hit=1, stat=8, retired=4, done=1.
- Reset asserted mid-EXECUTE.
  -> All outputs immediately return to reset values: p_ctr=0, stat=8, retired=0.
  -> With SEQ_STEP_EN defined: after one instruction the FSM holds in PAUSE for 20 cycles with no enables, and a step pulse resumes FETCH on the next edge.
